// File: rtl/beat_splitter_pkg.sv
// Shared sizing, types and state encoding for the beat splitter.
package beat_splitter_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_BEATS  = 4;

  // Sum of beats lanes of data_w bits each never needs more than this many bits.
  function automatic int unsigned sum_width(int unsigned data_w, int unsigned beats);
    return data_w + $clog2(beats);
  endfunction

  localparam int unsigned DEF_SUM_W = sum_width(DEF_DATA_W, DEF_BEATS);

  typedef logic [DEF_DATA_W-1:0] lane_t;
  typedef logic [DEF_SUM_W-1:0]  sum_t;

  typedef enum logic {StIdle, StSend} state_e;

endpackage

// File: rtl/beat_splitter_lane_sum.sv
// Combinational unsigned sum of all lanes of a packed word.
module lane_sum
  import beat_splitter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BEATS  = DEF_BEATS,
  parameter int unsigned SUM_W  = sum_width(DATA_W, BEATS)
) (
  input  logic [DATA_W*BEATS-1:0] word,
  output logic [SUM_W-1:0]        sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < BEATS; i++) begin
      sum = sum + SUM_W'(word[i*DATA_W +: DATA_W]);
    end
  end

endmodule

// File: rtl/beat_splitter.sv
// Width-down serializer: one BEATS-lane word in, lanes out LSB first with last flag and word sum.
module beat_splitter
  import beat_splitter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned BEATS  = DEF_BEATS,
  parameter int unsigned SUM_W  = sum_width(DATA_W, BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W*BEATS-1:0] data_in,
  input  logic                    valid_a,
  output logic                    ready_a,
  input  logic                    ready_b,
  output logic                    valid_b,
  output logic [DATA_W-1:0]       data_out,
  output logic                    last_b,
  output logic [SUM_W-1:0]        sum_out
);

  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned REST_W = DATA_W * (BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(BEATS - 2);

  state_e              state_q, state_d;
  logic [REST_W-1:0]   rest_q, rest_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic [SUM_W-1:0]    word_sum;
  logic                load;

  lane_sum #(
    .DATA_W (DATA_W),
    .BEATS  (BEATS),
    .SUM_W  (SUM_W)
  ) u_lane_sum (
    .word (data_in),
    .sum  (word_sum)
  );

  // Accept a new word when idle or in the same edge the final beat leaves.
  assign ready_a  = (state_q == StIdle) || (ready_b && last_q);
  assign load     = valid_a && ready_a;
  assign valid_b  = (state_q == StSend);
  assign data_out = data_q;
  assign last_b   = last_q;
  assign sum_out  = sum_q;

  always_comb begin
    state_d = state_q;
    rest_d  = rest_q;
    data_d  = data_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (load) begin
      state_d = StSend;
      data_d  = data_in[DATA_W-1:0];
      rest_d  = data_in[DATA_W*BEATS-1:DATA_W];
      sum_d   = word_sum;
      idx_d   = '0;
      last_d  = 1'b0;
    end else if (state_q == StSend && ready_b) begin
      if (last_q) begin
        state_d = StIdle;
        last_d  = 1'b0;
      end else begin
        // Lane 0 went straight to data_q, so rest_q only ever holds lanes still to come.
        data_d = rest_q[DATA_W-1:0];
        rest_d = rest_q >> DATA_W;
        idx_d  = idx_q + 1'b1;
        last_d = (idx_q == IDX_PENULT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rest_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rest_q  <= rest_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

endmodule
